// File: rtl/add16_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// add16_arbiter_if : two requester channels plus the result channel
// Rev 1.0
// ---------------------------------------------------------------------------
interface add16_arbiter_if;
  logic        req0_valid;
  logic [15:0] req0_a;
  logic [15:0] req0_b;
  logic        req0_ready;
  logic        req1_valid;
  logic [15:0] req1_a;
  logic [15:0] req1_b;
  logic        req1_ready;
  logic        res_valid;
  logic [15:0] res_data;
  logic        res_id;
  logic        res_ready;
  logic        busy;

  modport master (
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, res_ready,
    input  req0_ready, req1_ready, res_valid, res_data, res_id, busy
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, res_ready,
    output req0_ready, req1_ready, res_valid, res_data, res_id, busy
  );
endinterface
`default_nettype wire

// File: rtl/add16_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// add16_arbiter : two requesters share one 16-bit adder, one op in flight.
// Macro ADD16_ARB_ROUND_ROBIN_EN: round-robin ties (default: requester 0 wins)
// Rev 1.0
// ---------------------------------------------------------------------------
module my_add16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] sum
);
  assign sum = a + b;
endmodule

module add16_arbiter (
  input  logic            clk,
  input  logic            reset,
  add16_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_op_a;
  logic [15:0] r_op_b;
  logic        r_op_id;
  logic [15:0] r_res_data;
  logic        r_res_id;
  logic [15:0] w_sum;
  logic        w_pick1;
  logic        w_accept;

`ifdef ADD16_ARB_ROUND_ROBIN_EN
  logic r_last_grant;

  // On a tie, whichever requester was not served last goes next.
  assign w_pick1 = bus.req1_valid & (~bus.req0_valid | ~r_last_grant);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant <= 1'b1;
    end else if (w_accept) begin
      r_last_grant <= w_pick1;
    end
  end
`else
  assign w_pick1 = bus.req1_valid & ~bus.req0_valid;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_accept       = 1'b0;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    case (r_state)
      IDLE: begin
        if (!reset) begin
          bus.req0_ready = bus.req0_valid & ~w_pick1;
          bus.req1_ready = w_pick1;
          w_accept       = bus.req0_valid | bus.req1_valid;
        end
        if (w_accept) begin
          w_state_nxt = EXEC;
        end
      end
      EXEC: begin
        w_state_nxt = DONE;
      end
      DONE: begin
        if (bus.res_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  my_add16 u_add (
    .a   (r_op_a),
    .b   (r_op_b),
    .sum (w_sum)
  );

  // Operands are captured at the accept edge so later input changes are ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op_a     <= 16'h0000;
      r_op_b     <= 16'h0000;
      r_op_id    <= 1'b0;
      r_res_data <= 16'h0000;
      r_res_id   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op_a  <= w_pick1 ? bus.req1_a : bus.req0_a;
        r_op_b  <= w_pick1 ? bus.req1_b : bus.req0_b;
        r_op_id <= w_pick1;
      end
      if (r_state == EXEC) begin
        r_res_data <= w_sum;
        r_res_id   <= r_op_id;
      end
    end
  end

  assign bus.res_valid = (r_state == DONE);
  assign bus.busy      = (r_state != IDLE);
  assign bus.res_data  = r_res_data;
  assign bus.res_id    = r_res_id;
endmodule
`default_nettype wire

// File: tb/tb_add16_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_add16_arbiter : directed stimulus, transaction-level model, per-cycle compare
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_add16_arbiter;
`ifdef ADD16_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  bit   model_on = 1'b0;

  add16_arbiter_if bus ();

  add16_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: an op is in flight for a number of cycles since accept.
  bit          m_busy   = 1'b0;
  int          m_age    = 0;
  logic [15:0] m_pend   = 16'h0000;
  logic        m_pid    = 1'b0;
  logic [15:0] m_data   = 16'h0000;
  logic        m_res_id = 1'b0;
  logic        m_last   = 1'b1;

  function automatic logic m_winner();
    if (bus.req0_valid && bus.req1_valid) return RR ? ~m_last : 1'b0;
    return bus.req1_valid ? 1'b1 : 1'b0;
  endfunction

  function automatic logic m_ready(input int idx);
    logic v;
    v = (idx == 0) ? bus.req0_valid : bus.req1_valid;
    if (reset || m_busy || !v) return 1'b0;
    return (m_winner() == idx[0]);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_busy   = 1'b0;
      m_data   = 16'h0000;
      m_res_id = 1'b0;
      m_last   = 1'b1;
    end else if (!m_busy) begin
      if (m_ready(0) || m_ready(1)) begin
        m_pid  = m_winner();
        m_pend = m_pid ? (bus.req1_a + bus.req1_b) : (bus.req0_a + bus.req0_b);
        m_last = m_pid;
        m_busy = 1'b1;
        m_age  = 0;
      end
    end else if (m_age == 0) begin
      m_age    = 1;
      m_data   = m_pend;
      m_res_id = m_pid;
    end else if (bus.res_ready) begin
      m_busy = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      chk("cmp_req0_ready", bus.req0_ready, m_ready(0));
      chk("cmp_req1_ready", bus.req1_ready, m_ready(1));
      chk("cmp_res_valid", bus.res_valid, m_busy && (m_age >= 1));
      chk("cmp_busy", bus.busy, m_busy);
      chk("cmp_res_data", bus.res_data, m_data);
      chk("cmp_res_id", bus.res_id, m_res_id);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (bus.busy && n < 20) begin
      tick();
      n++;
    end
    chk(name, bus.busy, 1'b0);
  endtask

  logic        grants  [4];
  logic [15:0] results [4];
  logic        exp_g   [4];
  logic [15:0] exp_r   [4];

  initial begin
    int ng;
    int nr;
    bit seen1;
    reset          = 1'b1;
    bus.req0_valid = 1'b0;
    bus.req0_a     = 16'h0000;
    bus.req0_b     = 16'h0000;
    bus.req1_valid = 1'b0;
    bus.req1_a     = 16'h0000;
    bus.req1_b     = 16'h0000;
    bus.res_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_on = 1'b1;

    // Reset state; ready held low while reset is high
    bus.req0_valid = 1'b1;
    #1;
    chk("rst_req0_ready", bus.req0_ready, 1'b0);
    chk("rst_res_valid", bus.res_valid, 1'b0);
    chk("rst_res_data", bus.res_data, 16'h0000);
    chk("rst_res_id", bus.res_id, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    bus.req0_valid = 1'b0;
    tick();
    reset = 1'b0;

    // Single op 3+4 with latency
    tick();
    bus.req0_valid = 1'b1;
    bus.req0_a     = 16'h0003;
    bus.req0_b     = 16'h0004;
    #1;
    chk("a_ready0", bus.req0_ready, 1'b1);
    tick();
    bus.req0_valid = 1'b0;
    #1;
    chk("a_busy_exec", bus.busy, 1'b1);
    chk("a_valid_exec", bus.res_valid, 1'b0);
    tick();
    chk("a_res_valid", bus.res_valid, 1'b1);
    chk("a_res_data", bus.res_data, 16'h0007);
    chk("a_res_id", bus.res_id, 1'b0);
    chk("a_busy_done", bus.busy, 1'b1);
    bus.res_ready = 1'b1;
    tick();
    chk("a_idle_busy", bus.busy, 1'b0);
    chk("a_idle_valid", bus.res_valid, 1'b0);
    bus.res_ready = 1'b0;

    // Backpressure in DONE
    bus.req0_valid = 1'b1;
    bus.req0_a     = 16'h1234;
    bus.req0_b     = 16'h0001;
    tick();
    bus.req0_valid = 1'b0;
    tick();
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("b_res_data", bus.res_data, 16'h1235);
      chk("b_res_id", bus.res_id, 1'b0);
      chk("b_ready0", bus.req0_ready, 1'b0);
      chk("b_ready1", bus.req1_ready, 1'b0);
      tick();
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.res_ready  = 1'b1;
    tick();
    chk("b_idle_after", bus.busy, 1'b0);

    // Contention from a fresh reset
    reset = 1'b1;
    tick();
    reset          = 1'b0;
    bus.req0_a     = 16'h0010;
    bus.req0_b     = 16'h0001;
    bus.req1_a     = 16'h0020;
    bus.req1_b     = 16'h0002;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    bus.res_ready  = 1'b1;
    ng = 0;
    nr = 0;
    seen1 = 1'b0;
    for (int c = 0; c < 40 && (ng < 4 || nr < 4); c++) begin
      #1;
      if (bus.req1_ready) seen1 = 1'b1;
      if (bus.req0_ready || bus.req1_ready) begin
        if (ng < 4) grants[ng] = bus.req1_ready;
        ng++;
      end
      if (bus.res_valid) begin
        if (nr < 4) results[nr] = bus.res_data;
        nr++;
      end
      tick();
    end
    chk("c_enough_grants", 32'(ng >= 4), 32'd1);
    chk("c_enough_results", 32'(nr >= 4), 32'd1);
`ifdef ADD16_ARB_ROUND_ROBIN_EN
    exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
    exp_r = '{16'h0011, 16'h0022, 16'h0011, 16'h0022};
`else
    exp_g = '{1'b0, 1'b0, 1'b0, 1'b0};
    exp_r = '{16'h0011, 16'h0011, 16'h0011, 16'h0011};
    chk("c_req1_never", seen1, 1'b0);
`endif
    for (int i = 0; i < 4; i++) begin
      if (i < ng) chk($sformatf("c_grant%0d", i), grants[i], exp_g[i]);
      if (i < nr) chk($sformatf("c_result%0d", i), results[i], exp_r[i]);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    wait_idle("c_drain");

    // Reset while an op from requester 0 is in EXEC
    bus.res_ready  = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req0_a     = 16'h0005;
    bus.req0_b     = 16'h0006;
    tick();
    bus.req0_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("d_busy_exec", bus.busy, 1'b1);
    tick();
    reset = 1'b0;
    #1;
    chk("d_busy", bus.busy, 1'b0);
    chk("d_res_valid", bus.res_valid, 1'b0);
    chk("d_res_data", bus.res_data, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("d_no_result", bus.res_valid, 1'b0);
    end
    bus.req0_a     = 16'h0001;
    bus.req0_b     = 16'h0001;
    bus.req1_a     = 16'h0002;
    bus.req1_b     = 16'h0002;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    #1;
    chk("d_tie_ready0", bus.req0_ready, 1'b1);
    chk("d_tie_ready1", bus.req1_ready, 1'b0);
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.res_ready  = 1'b1;
    wait_idle("d_drain");

    // Operand change after accept, lone requester 1
    bus.res_ready  = 1'b0;
    bus.req1_valid = 1'b1;
    bus.req1_a     = 16'h0100;
    bus.req1_b     = 16'h0002;
    #1;
    chk("e_ready1", bus.req1_ready, 1'b1);
    chk("e_ready0", bus.req0_ready, 1'b0);
    tick();
    bus.req1_a = 16'hAAAA;
    bus.req1_b = 16'h5555;
    #1;
    chk("e_ready1_exec", bus.req1_ready, 1'b0);
    tick();
    chk("e_res_data", bus.res_data, 16'h0102);
    chk("e_res_id", bus.res_id, 1'b1);
    bus.req1_valid = 1'b0;
    bus.res_ready  = 1'b1;
    wait_idle("e_drain");

    // Carry-out is dropped
    bus.res_ready  = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req0_a     = 16'hFFFF;
    bus.req0_b     = 16'h0002;
    tick();
    bus.req0_valid = 1'b0;
    tick();
    chk("f_res_data", bus.res_data, 16'h0001);
    bus.res_ready = 1'b1;
    wait_idle("f_drain");

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
